level_advance_ctrl: RTL and testbench

- Producer side of the level-up handshake. Counts correct and incorrect player answers.
- After HITS_PER_LEVEL correct answers, issues a single-cycle incLevel request to the level controller, then waits for its newLevel acknowledge.
- Ends the game as won at MAX_LEVEL, or as lost after MISS_LIMIT misses.
- Sits between the answer-checking logic and the level controller; runs on the 100 MHz system clock.

---
 rtl/level_advance_ctrl_pkg.sv | 27 ++
 rtl/level_advance_ctrl_timer.sv | 38 +++
 rtl/level_advance_ctrl.sv | 155 +++++++++++++++
 tb/tb_level_advance_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/level_advance_ctrl_pkg.sv
// Shared definitions for the level-advance producer.
// Contents:
//   state_t            - FSM states of level_advance_ctrl
//   LEVEL_W            - width of level and answer counters
//   DEF_*              - default parameter values
//   cnt_width()        - counter width needed to hold 0..n-1 (at least 1 bit)
package level_advance_ctrl_pkg;

    localparam int LEVEL_W            = 4;
    localparam int DEF_HITS_PER_LEVEL = 5;
    localparam int DEF_MAX_LEVEL      = 15;
    localparam int DEF_MISS_LIMIT     = 3;
    localparam int DEF_ACK_TIMEOUT    = 15;

    typedef enum logic [2:0] {
        PLAY     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        WON      = 3'd3,
        LOST     = 3'd4
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/level_advance_ctrl_timer.sv
// ack_timeout_timer: load/count/expire counter for a request/acknowledge
// handshake. The count is cleared by load, advances while count is high and
// stops once it reaches TIMEOUT-1, where expired is asserted.
// Ports:
//   Clk100M  in   system clock
//   RstN     in   asynchronous active-low reset
//   load     in   clear the count to 0
//   count    in   advance the count by one
//   expired  out  count has reached TIMEOUT-1
module ack_timeout_timer
    import level_advance_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic Clk100M,
    input  logic RstN,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/level_advance_ctrl.sv
// level_advance_ctrl: producer side of the level-up handshake. Counts correct
// and wrong answers, requests a level-up after HITS_PER_LEVEL hits, waits for
// the level controller's acknowledge, and ends the game as won or lost.
// Ports:
//   Clk100M        in   system clock (100 MHz)
//   RstN           in   asynchronous active-low reset
//   restart        in   synchronous clear back to PLAY, highest priority
//   answerValid    in   one-cycle answer strobe
//   answerCorrect  in   1 = correct answer, 0 = wrong
//   newLevel       in   acknowledge from the level controller
//   curLevel       in   current level from the level controller
//   incLevel       out  one-cycle level-up request
//   hitCnt         out  hits counted toward the next level
//   missCnt        out  wrong answers this game
//   gameWon        out  game won
//   gameLost       out  game lost
//   ackError       out  sticky acknowledge timeout flag
//   answerDropped  out  one-cycle pulse: answer ignored outside PLAY
module level_advance_ctrl
    import level_advance_ctrl_pkg::*;
#(
    parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int MISS_LIMIT     = DEF_MISS_LIMIT,
    parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
    input  logic               Clk100M,
    input  logic               RstN,
    input  logic               restart,
    input  logic               answerValid,
    input  logic               answerCorrect,
    input  logic               newLevel,
    input  logic [LEVEL_W-1:0] curLevel,
    output logic               incLevel,
    output logic [LEVEL_W-1:0] hitCnt,
    output logic [LEVEL_W-1:0] missCnt,
    output logic               gameWon,
    output logic               gameLost,
    output logic               ackError,
    output logic               answerDropped
);

    if (HITS_PER_LEVEL < 1 || HITS_PER_LEVEL > 15) begin : g_chk_hits
        $error("HITS_PER_LEVEL must be in 1..15");
    end
    if (MISS_LIMIT < 1 || MISS_LIMIT > 15) begin : g_chk_miss
        $error("MISS_LIMIT must be in 1..15");
    end
    if (MAX_LEVEL < 0 || MAX_LEVEL > 15) begin : g_chk_level
        $error("MAX_LEVEL must fit in 4 bits");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_chk_timeout
        $error("ACK_TIMEOUT must be in 1..255");
    end

    state_t             state, stateNext;
    logic [LEVEL_W-1:0] hitNext, missNext, missInc;
    logic               incNext, errNext, dropNext;
    logic               timerLoad, timerCount, timerExpired;

    ack_timeout_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .Clk100M (Clk100M),
        .RstN    (RstN),
        .load    (timerLoad),
        .count   (timerCount),
        .expired (timerExpired)
    );

    assign missInc = missCnt + LEVEL_W'(1);

    always_comb begin
        stateNext  = state;
        hitNext    = hitCnt;
        missNext   = missCnt;
        incNext    = 1'b0;
        errNext    = ackError;
        dropNext   = 1'b0;
        timerLoad  = 1'b0;
        timerCount = 1'b0;

        if (restart) begin
            // restart discards any answer in the same cycle without a drop pulse
            stateNext = PLAY;
            hitNext   = '0;
            missNext  = '0;
            errNext   = 1'b0;
            timerLoad = 1'b1;
        end else begin
            dropNext = answerValid && (state != PLAY);
            case (state)
                PLAY: begin
                    if (answerValid && answerCorrect) begin
                        if (hitCnt == LEVEL_W'(HITS_PER_LEVEL - 1)) begin
                            hitNext   = '0;
                            stateNext = REQ;
                        end else begin
                            hitNext = hitCnt + LEVEL_W'(1);
                        end
                    end else if (answerValid) begin
                        // LOST is terminal, so missCnt never advances past the limit
                        missNext = missInc;
                        if (missInc == LEVEL_W'(MISS_LIMIT)) begin
                            stateNext = LOST;
                        end
                    end
                end
                REQ: begin
                    if (curLevel >= LEVEL_W'(MAX_LEVEL)) begin
                        stateNext = WON;
                    end else begin
                        incNext   = 1'b1;
                        timerLoad = 1'b1;
                        stateNext = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (newLevel) begin
                        stateNext = PLAY;
                    end else if (timerExpired) begin
                        errNext   = 1'b1;
                        stateNext = PLAY;
                    end else begin
                        timerCount = 1'b1;
                    end
                end
                default: ;  // WON and LOST hold until restart or reset
            endcase
        end
    end

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            state         <= PLAY;
            incLevel      <= 1'b0;
            hitCnt        <= '0;
            missCnt       <= '0;
            gameWon       <= 1'b0;
            gameLost      <= 1'b0;
            ackError      <= 1'b0;
            answerDropped <= 1'b0;
        end else begin
            state         <= stateNext;
            incLevel      <= incNext;
            hitCnt        <= hitNext;
            missCnt       <= missNext;
            gameWon       <= (stateNext == WON);
            gameLost      <= (stateNext == LOST);
            ackError      <= errNext;
            answerDropped <= dropNext;
        end
    end

endmodule

// File: tb/tb_level_advance_ctrl.sv
module tb_level_advance_ctrl;

    localparam int HITS  = 5;
    localparam int MAXL  = 15;
    localparam int MISSL = 3;
    localparam int TOUT  = 15;

    logic       Clk100M = 1'b0;
    logic       RstN = 1'b0;
    logic       restart = 1'b0;
    logic       answerValid = 1'b0;
    logic       answerCorrect = 1'b0;
    logic       newLevel = 1'b0;
    logic [3:0] curLevel = 4'd1;
    logic       incLevel;
    logic [3:0] hitCnt;
    logic [3:0] missCnt;
    logic       gameWon;
    logic       gameLost;
    logic       ackError;
    logic       answerDropped;

    int total = 0;
    int bad   = 0;
    bit ackMode = 1'b0;   // when set, newLevel echoes incLevel one cycle later

    // Reference model: game progress in plain terms.
    // reqAge: 0 = taking answers; 1 = level-up decision pending;
    //         k >= 2 = waiting for acknowledge for (k-2) cycles.
    int mHits, mMiss, reqAge;
    bit mWon, mLost, mErr, mInc, mDrop;

    level_advance_ctrl #(
        .HITS_PER_LEVEL (HITS),
        .MAX_LEVEL      (MAXL),
        .MISS_LIMIT     (MISSL),
        .ACK_TIMEOUT    (TOUT)
    ) dut (
        .Clk100M       (Clk100M),
        .RstN          (RstN),
        .restart       (restart),
        .answerValid   (answerValid),
        .answerCorrect (answerCorrect),
        .newLevel      (newLevel),
        .curLevel      (curLevel),
        .incLevel      (incLevel),
        .hitCnt        (hitCnt),
        .missCnt       (missCnt),
        .gameWon       (gameWon),
        .gameLost      (gameLost),
        .ackError      (ackError),
        .answerDropped (answerDropped)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic model_clear();
        mHits = 0; mMiss = 0; reqAge = 0;
        mWon = 0; mLost = 0; mErr = 0; mInc = 0; mDrop = 0;
    endtask

    task automatic model_edge();
        mInc  = 0;
        mDrop = 0;
        if (!RstN || restart) begin
            model_clear();
        end else if (mWon || mLost) begin
            mDrop = answerValid;
        end else if (reqAge == 0) begin
            if (answerValid && answerCorrect) begin
                mHits++;
                if (mHits == HITS) begin
                    mHits  = 0;
                    reqAge = 1;
                end
            end else if (answerValid) begin
                mMiss++;
                if (mMiss == MISSL) mLost = 1;
            end
        end else if (reqAge == 1) begin
            mDrop = answerValid;
            if (int'(curLevel) >= MAXL) begin
                mWon   = 1;
                reqAge = 0;
            end else begin
                mInc   = 1;
                reqAge = 2;
            end
        end else begin
            mDrop = answerValid;
            if (newLevel) reqAge = 0;
            else if (reqAge - 2 == TOUT - 1) begin
                mErr   = 1;
                reqAge = 0;
            end else reqAge++;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("incLevel", int'(incLevel), int'(mInc));
        check("hitCnt", int'(hitCnt), mHits);
        check("missCnt", int'(missCnt), mMiss);
        check("gameWon", int'(gameWon), int'(mWon));
        check("gameLost", int'(gameLost), int'(mLost));
        check("ackError", int'(ackError), int'(mErr));
        check("answerDropped", int'(answerDropped), int'(mDrop));
    endtask

    // One clock: model follows the edge, outputs compared 1 ns after it.
    task automatic step();
        @(posedge Clk100M);
        model_edge();
        #1;
        check_all();
        if (ackMode) newLevel = incLevel;
    endtask

    task automatic answer(input bit c);
        answerValid   = 1'b1;
        answerCorrect = c;
        step();
        answerValid   = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_clear();

        // reset state
        #2;
        check_all();
        idle(2);
        @(negedge Clk100M);
        RstN = 1'b1;
        idle(1);

        // five hits with a prompt acknowledge, then an answer right after
        curLevel = 4'd1;
        ackMode  = 1'b1;
        for (int i = 0; i < HITS; i++) begin
            answer(1'b1);
            idle($urandom_range(0, 2));
        end
        idle(6);
        answer(1'b1);
        check("hit_after_levelup", int'(hitCnt), 1);

        // C W C W W -> lost, then a dropped answer
        do_restart();
        answer(1'b1); answer(1'b0); answer(1'b1); answer(1'b0); answer(1'b0);
        check("lost_flag", int'(gameLost), 1);
        check("lost_hits", int'(hitCnt), 2);
        answer(1'b1);
        check("lost_drop", int'(answerDropped), 1);
        idle(1);

        // top level reached -> win with no request
        do_restart();
        curLevel = 4'd15;
        for (int i = 0; i < HITS; i++) answer(1'b1);
        idle(3);
        check("won_flag", int'(gameWon), 1);
        answer(1'b0);
        check("won_miss_hold", int'(missCnt), 0);

        // restart in WON
        do_restart();
        check("restart_won", int'(gameWon), 0);

        // acknowledge never arrives -> sticky error, later level-up still works
        curLevel = 4'd3;
        ackMode  = 1'b0;
        newLevel = 1'b0;
        for (int i = 0; i < HITS; i++) answer(1'b1);
        idle(TOUT + 4);
        check("ack_error", int'(ackError), 1);
        ackMode = 1'b1;
        for (int i = 0; i < HITS; i++) answer(1'b1);
        idle(5);
        answer(1'b0);
        check("err_sticky", int'(ackError), 1);

        // answers during WAIT_ACK are dropped
        do_restart();
        ackMode = 1'b0;
        for (int i = 0; i < HITS; i++) answer(1'b1);
        idle(2);
        answer(1'b1);
        answer(1'b0);
        newLevel = 1'b1;
        step();
        newLevel = 1'b0;
        idle(2);

        // newLevel high across reset release is ignored
        @(negedge Clk100M);
        RstN = 1'b0;
        newLevel = 1'b1;
        model_clear();
        idle(2);
        @(negedge Clk100M);
        RstN = 1'b1;
        idle(4);
        newLevel = 1'b0;

        // reset during the request cycle clears incLevel at once
        for (int i = 0; i < HITS; i++) answer(1'b1);
        step();
        check("req_pulse", int'(incLevel), 1);
        RstN = 1'b0;
        model_clear();
        #1;
        check_all();
        idle(1);
        @(negedge Clk100M);
        RstN = 1'b1;
        idle(3);

        // randomized play against the model
        ackMode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            restart       = ($urandom_range(0, 80) == 0);
            answerValid   = ($urandom_range(0, 2) == 0);
            answerCorrect = ($urandom_range(0, 4) != 0);
            newLevel      = ($urandom_range(0, 5) == 0);
            curLevel      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            step();
        end
        restart = 1'b0;
        answerValid = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
